alsu_arbiter: RTL and testbench

- Shares one ALSU instance between two command requesters.
- Accepts one packed command at a time using round-robin arbitration.
- Screens out commands the ALSU treats as invalid; these are rejected locally, so the ALSU never enters its LED-blink error mode.
- For valid commands, drives the ALSU inputs, waits out the fixed pipeline latency, then returns the ALSU result with a requester ID over a valid/ready response channel.

---
 rtl/alsu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alsu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_arbiter.sv
// alsu_arbiter: round-robin front end that shares one ALSU between two
// requesters, screens out commands the ALSU would flag as invalid, waits out
// the ALSU pipeline and returns the captured result over a valid/ready channel.
`timescale 1ns/1ps
module alsu_arbiter #(
    parameter int WIDTH        = 3,
    parameter int ALSU_LATENCY = 2,
    // {opcode[2:0], A, B, cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction}
    parameter int CMD_W        = 3 + 2*WIDTH + 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid_0,
    input  logic [CMD_W-1:0]     req_cmd_0,
    output logic                 req_ready_0,
    input  logic                 req_valid_1,
    input  logic [CMD_W-1:0]     req_cmd_1,
    output logic                 req_ready_1,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [2*WIDTH-1:0]   resp_data,
    output logic                 resp_err,
    output logic [2:0]           alsu_opcode,
    output logic [WIDTH-1:0]     alsu_A,
    output logic [WIDTH-1:0]     alsu_B,
    output logic                 alsu_cin,
    output logic                 alsu_serial_in,
    output logic                 alsu_red_op_A,
    output logic                 alsu_red_op_B,
    output logic                 alsu_bypass_A,
    output logic                 alsu_bypass_B,
    output logic                 alsu_direction,
    input  logic [2*WIDTH-1:0]   alsu_out
);

    localparam int CNT_W = (ALSU_LATENCY < 1) ? 1 : $clog2(ALSU_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic               rr;
    logic [CNT_W-1:0]   cnt;

    logic               grant_id;
    logic               accept;
    logic [CMD_W-1:0]   cmd;
    logic [2:0]         cmd_op;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic               cmd_bad;

    // Opcodes 6/7 are illegal; reduction is only defined for AND/XOR.
    // Bypass does not rescue a command that fails this screen.
    function automatic logic cmd_invalid(input logic [2:0] op,
                                         input logic       red_a,
                                         input logic       red_b);
        return (op == 3'd6) || (op == 3'd7) || ((red_a | red_b) && (op > 3'd1));
    endfunction

    // Round-robin grant only matters when both requesters contend.
    assign grant_id    = (req_valid_0 & req_valid_1) ? rr : req_valid_1;
    assign accept      = !rst && (state == IDLE) && (req_valid_0 | req_valid_1);
    assign req_ready_0 = accept && !grant_id;
    assign req_ready_1 = accept &&  grant_id;

    assign cmd     = grant_id ? req_cmd_1 : req_cmd_0;
    assign cmd_op  = cmd[CMD_W-1 -: 3];
    assign cmd_a   = cmd[7+2*WIDTH-1 -: WIDTH];
    assign cmd_b   = cmd[7+WIDTH-1 -: WIDTH];
    assign cmd_bad = cmd_invalid(cmd_op, cmd[4], cmd[3]);

    assign resp_valid = (state == RESP);

    // Next-state selection for the single-outstanding-command FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)          state_nxt = cmd_bad ? RESP : WAIT;
            WAIT: if (cnt == '0)       state_nxt = RESP;
            RESP: if (resp_ready)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Arbitration pointer, ALSU drive, latency counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr             <= 1'b0;
            cnt            <= '0;
            resp_id        <= 1'b0;
            resp_data      <= '0;
            resp_err       <= 1'b0;
            alsu_opcode    <= 3'd0;
            alsu_A         <= '0;
            alsu_B         <= '0;
            alsu_cin       <= 1'b0;
            alsu_serial_in <= 1'b0;
            alsu_red_op_A  <= 1'b0;
            alsu_red_op_B  <= 1'b0;
            alsu_bypass_A  <= 1'b0;
            alsu_bypass_B  <= 1'b0;
            alsu_direction <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr      <= ~grant_id;
                        resp_id <= grant_id;
                        if (cmd_bad) begin
                            resp_err  <= 1'b1;
                            resp_data <= '0;
                        end else begin
                            alsu_opcode    <= cmd_op;
                            alsu_A         <= cmd_a;
                            alsu_B         <= cmd_b;
                            alsu_cin       <= cmd[6];
                            alsu_serial_in <= cmd[5];
                            alsu_red_op_A  <= cmd[4];
                            alsu_red_op_B  <= cmd[3];
                            alsu_bypass_A  <= cmd[2];
                            alsu_bypass_B  <= cmd[1];
                            alsu_direction <= cmd[0];
                            cnt            <= CNT_W'(ALSU_LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_data <= alsu_out;
                        resp_err  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        alsu_opcode    <= 3'd0;
                        alsu_A         <= '0;
                        alsu_B         <= '0;
                        alsu_cin       <= 1'b0;
                        alsu_serial_in <= 1'b0;
                        alsu_red_op_A  <= 1'b0;
                        alsu_red_op_B  <= 1'b0;
                        alsu_bypass_A  <= 1'b0;
                        alsu_bypass_B  <= 1'b0;
                        alsu_direction <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Testbench for alsu_arbiter: behavioural two-register ALSU (priority A,
// full adder on) plus a response scoreboard.
`timescale 1ns/1ps
module tb_alsu_arbiter;

    localparam int W     = 3;
    localparam int LAT   = 2;
    localparam int CMD_W = 3 + 2*W + 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_0, req_valid_1;
    logic [CMD_W-1:0] req_cmd_0, req_cmd_1;
    logic             req_ready_0, req_ready_1;
    logic             resp_valid, resp_ready, resp_id, resp_err;
    logic [2*W-1:0]   resp_data;
    logic [2:0]       alsu_opcode;
    logic [W-1:0]     alsu_A, alsu_B;
    logic             alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
    logic             alsu_bypass_A, alsu_bypass_B, alsu_direction;
    logic [2*W-1:0]   alsu_out = '0;

    typedef struct packed {
        logic           id;
        logic [2*W-1:0] data;
        logic           err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    alsu_arbiter #(.WIDTH(W), .ALSU_LATENCY(LAT), .CMD_W(CMD_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_cmd_0(req_cmd_0), .req_ready_0(req_ready_0),
        .req_valid_1(req_valid_1), .req_cmd_1(req_cmd_1), .req_ready_1(req_ready_1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err),
        .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_direction(alsu_direction), .alsu_out(alsu_out)
    );

    // ---------------- behavioural ALSU: input regs, then out reg ----------------
    logic [2:0]   m_op = '0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_cin = 1'b0, m_si = 1'b0, m_ra = 1'b0, m_rb = 1'b0;
    logic         m_ba = 1'b0, m_bb = 1'b0, m_dir = 1'b0;

    function automatic logic [2*W-1:0] alsu_f(input logic [2:0] op, input logic [W-1:0] a, b,
                                              input logic cin, si, ra, rb, ba, bb, dir,
                                              input logic [2*W-1:0] prev);
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        if (ba)      return ea;
        else if (bb) return eb;
        case (op)
            3'd0: return ra ? {{(2*W-1){1'b0}}, &a} : rb ? {{(2*W-1){1'b0}}, &b} : (ea & eb);
            3'd1: return ra ? {{(2*W-1){1'b0}}, ^a} : rb ? {{(2*W-1){1'b0}}, ^b} : (ea ^ eb);
            3'd2: return ea + eb + {{(2*W-1){1'b0}}, cin};
            3'd3: return ea * eb;
            3'd4: return dir ? {prev[2*W-2:0], si} : {si, prev[2*W-1:1]};
            3'd5: return dir ? {prev[2*W-2:0], prev[2*W-1]} : {prev[0], prev[2*W-1:1]};
            default: return prev;
        endcase
    endfunction

    always @(posedge clk) begin
        m_op <= alsu_opcode; m_a <= alsu_A; m_b <= alsu_B; m_cin <= alsu_cin;
        m_si <= alsu_serial_in; m_ra <= alsu_red_op_A; m_rb <= alsu_red_op_B;
        m_ba <= alsu_bypass_A; m_bb <= alsu_bypass_B; m_dir <= alsu_direction;
        alsu_out <= alsu_f(m_op, m_a, m_b, m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir, alsu_out);
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Response monitor: every handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_id",   32'(resp_id),   32'(mon_e.id));
                chk("resp_data", 32'(resp_data), 32'(mon_e.data));
                chk("resp_err",  32'(resp_err),  32'(mon_e.err));
            end
        end
    end

    function automatic logic [CMD_W-1:0] mk(input logic [2:0] op, input logic [W-1:0] a, b,
                                            input logic c, ra, rb);
        return {op, a, b, c, 1'b0, ra, rb, 3'b000};
    endfunction

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    // Present a command and hold it until granted; returns in the cycle after accept.
    task automatic accept(input bit id, input logic [CMD_W-1:0] cmd);
        bit ok;
        ok = 0;
        if (id) begin req_valid_1 = 1'b1; req_cmd_1 = cmd; end
        else    begin req_valid_0 = 1'b1; req_cmd_0 = cmd; end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((id ? req_ready_1 : req_ready_0) === 1'b1) begin ok = 1; break; end
            next_cyc();
        end
        chk("accept_seen", 32'(ok), 32'd1);
        chk("other_ready_low", 32'(id ? req_ready_0 : req_ready_1), 32'd0);
        next_cyc();
        if (id) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
    endtask

    // Cycle index (accept = 0) at which resp_valid is first seen.
    task automatic wait_valid(output int n);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) break;
            n++;
            next_cyc();
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) next_cyc();
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        req_cmd_0 = '0; req_cmd_1 = '0; resp_ready = 1'b1;

        // Reset state, and ready held low while rst is high
        repeat (2) next_cyc();
        req_valid_0 = 1'b1; req_cmd_0 = mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_ready0",    32'(req_ready_0), 32'd0);
        chk("rst_resp_valid",32'(resp_valid),  32'd0);
        chk("rst_resp_data", 32'(resp_data),   32'd0);
        chk("rst_resp_err",  32'(resp_err),    32'd0);
        chk("rst_resp_id",   32'(resp_id),     32'd0);
        chk("rst_alsu_op",   32'(alsu_opcode), 32'd0);
        chk("rst_alsu_A",    32'(alsu_A),      32'd0);
        next_cyc();
        req_valid_0 = 1'b0; rst = 1'b0;

        // Add: 3 + 2 + cin 1 = 6, response at cycle 4
        exp_q.push_back('{id: 1'b0, data: 6'd6, err: 1'b0});
        accept(1'b0, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0));
        wait_valid(n);
        chk("add_latency", 32'(n), 32'd4);
        next_cyc();

        // Invalid opcode from requester 1: rejected at cycle 1, ALSU untouched
        exp_q.push_back('{id: 1'b1, data: 6'd0, err: 1'b1});
        accept(1'b1, mk(3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        wait_valid(n);
        chk("rej_latency", 32'(n), 32'd1);
        chk("rej_alsu_op", 32'(alsu_opcode), 32'd0);
        next_cyc();

        // Contention: both valid, multiply, grants alternate starting at 0
        req_cmd_0 = mk(3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
        req_cmd_1 = mk(3'd3, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if ((req_ready_0 | req_ready_1) === 1'b1) begin seen = 1; break; end
                next_cyc();
            end
            chk("rr_seen",   32'(seen), 32'd1);
            chk("rr_grant",  32'(req_ready_1), 32'(k % 2));
            chk("rr_onehot", 32'(req_ready_0 & req_ready_1), 32'd0);
            exp_q.push_back('{id: 1'((k % 2) != 0), data: ((k % 2) != 0) ? 6'd6 : 6'd9, err: 1'b0});
            next_cyc();
            if (k == 3) begin req_valid_0 = 1'b0; req_valid_1 = 1'b0; end
        end
        drain("rr_drain");

        // Reduction screen: add with red_op_A rejected; XOR reductions allowed
        exp_q.push_back('{id: 1'b0, data: 6'd0, err: 1'b1});
        accept(1'b0, mk(3'd2, 3'd5, 3'd1, 1'b0, 1'b1, 1'b0));
        wait_valid(n);
        chk("red_rej_latency", 32'(n), 32'd1);
        next_cyc();
        exp_q.push_back('{id: 1'b0, data: 6'd0, err: 1'b0});
        accept(1'b0, mk(3'd1, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0));
        wait_valid(n);
        chk("red_xor_latency", 32'(n), 32'd4);
        next_cyc();
        exp_q.push_back('{id: 1'b0, data: 6'd1, err: 1'b0});
        accept(1'b0, mk(3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0));
        wait_valid(n);
        next_cyc();

        // Backpressure: consumer stalls 5 cycles while requester 1 waits
        resp_ready = 1'b0;
        exp_q.push_back('{id: 1'b0, data: 6'd2, err: 1'b0});
        accept(1'b0, mk(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0));
        wait_valid(n);
        chk("bp_latency", 32'(n), 32'd4);
        req_valid_1 = 1'b1; req_cmd_1 = mk(3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid",  32'(resp_valid),  32'd1);
            chk("bp_data",   32'(resp_data),   32'd2);
            chk("bp_id",     32'(resp_id),     32'd0);
            chk("bp_err",    32'(resp_err),    32'd0);
            chk("bp_ready0", 32'(req_ready_0), 32'd0);
            chk("bp_ready1", 32'(req_ready_1), 32'd0);
            next_cyc();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_ready1", 32'(req_ready_1), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("bp_resume", 32'(req_ready_1), 32'd1);
        exp_q.push_back('{id: 1'b1, data: 6'd4, err: 1'b0});
        next_cyc();
        req_valid_1 = 1'b0;
        wait_valid(n);
        chk("bp2_latency", 32'(n), 32'd4);
        next_cyc();

        // Reset during WAIT: command dropped, outputs cleared, rr back to 0
        accept(1'b0, mk(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0));
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_alsu_op",  32'(alsu_opcode), 32'd0);
        chk("mid_rst_alsu_A",   32'(alsu_A),      32'd0);
        chk("mid_rst_alsu_B",   32'(alsu_B),      32'd0);
        chk("mid_rst_alsu_cin", 32'(alsu_cin),    32'd0);
        chk("mid_rst_valid",    32'(resp_valid),  32'd0);
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            @(negedge clk);
            chk("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        end
        next_cyc();
        req_cmd_0 = mk(3'd3, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0);
        req_cmd_1 = mk(3'd3, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        req_valid_0 = 1'b1; req_valid_1 = 1'b1;
        @(negedge clk);
        chk("mid_rst_rr0", 32'(req_ready_0), 32'd1);
        exp_q.push_back('{id: 1'b0, data: 6'd4, err: 1'b0});
        next_cyc();
        req_valid_0 = 1'b0; req_valid_1 = 1'b0;
        wait_valid(n);
        chk("post_rst_latency", 32'(n), 32'd4);
        next_cyc();
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
